mxv_rx_decoder: RTL and testbench
=================================

# mxv_rx_decoder

Upstream front end of the matrix-vector frame path: receives the 8N1 UART line, deserializes characters, and decodes ASCII hex digits and the field separator `_` into the symbol stream consumed by the frame control FSM. It drives that FSM's `rcv`, `data`, `cc_ovf` and `counter` inputs. Hex characters are paired into bytes; each completed pair raises `cc_ovf` and advances a byte counter.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `COUNT_W`, default 8: width of `counter`.
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous UART serial input; idle high.
- `cnt_clr` in 1: synchronous clear of `counter` and of the pending hex nibble; asserted by control on frame restart.
- `rcv` out 1: one-cycle pulse per accepted character (hex digit or `_`).
- `data` out 9: decoded symbol (`data_dec_t`). Hex pair gives `{1'b0, byte}`. `_` gives `UNDERSCORE` = 9'h15F. First nibble of a pair gives `{5'b0, nibble}`. Bit 8 set only for `_`, so byte 0x5F never aliases the separator.
- `cc_ovf` out 1: one-cycle pulse when the second hex digit of a pair is accepted; coincides with `rcv`.
- `counter` out COUNT_W: number of completed hex pairs since the last clear; saturates at all-ones.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `char_err` out 1: one-cycle pulse on an illegal character, or on `_` arriving while a nibble is pending.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- RX FSM states:
  - IDLE: waits for synchronized `rx` = 0, then goes to START.
  - START: at `CLKS_PER_BIT/2` re-samples. If 1, treat as a glitch and return to IDLE. If 0, reset the bit timer and go to DATA.
  - DATA: samples 8 bits LSB-first, each at `CLKS_PER_BIT` intervals from the start-bit midpoint, then goes to STOP.
  - STOP: samples at mid-bit. If 1, the byte is valid; go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stays until `rx` = 1, then goes to IDLE.
- Decoder, for each valid byte:
  - `'0'`–`'9'`, `'A'`–`'F'`, `'a'`–`'f'` map to a nibble.
    - No nibble pending: store it as the high nibble, set pending, pulse `rcv`, output `data` = {5'b0, nibble}.
    - Nibble pending: output `data` = {1'b0, hi, lo}, pulse `rcv` and `cc_ovf`, clear pending, increment `counter` (saturating).
  - `_` (0x5F): pulse `rcv`, output `data` = 9'h15F. If a nibble was pending, discard it, clear pending, and also pulse `char_err`.
  - Any other byte: pulse `char_err` only. No `rcv`, `data` holds, pending is unchanged.
- `data` holds its last value between `rcv` pulses.
- `cnt_clr`:
  - Zeroes `counter` and clears pending.
  - On the same cycle as a pair completion, clear wins: `counter` = 0 and `cc_ovf` still pulses.
  - A first nibble decoded on the same cycle as `cnt_clr` is discarded, but its `rcv` still pulses.

## Timing
- Reset values: `rcv`, `cc_ovf`, `frame_err`, `char_err` = 0; `data` = 0; `counter` = 0; pending = 0; RX FSM in IDLE; synchronizer flops = 1.
- `rcv`, `data`, `cc_ovf`, `char_err` are registered and assert exactly 1 cycle after the stop-bit sample cycle.
- `frame_err` asserts 1 cycle after the stop-bit sample.
- Total latency from the stop-bit midpoint on the pin to `rcv` is 3 cycles (2 synchronizer + 1 output).
- Minimum spacing between `rcv` pulses is one character time; no back-pressure is needed. Control must sample every pulse.
- Assertion of `rst` mid-character aborts reception immediately. The partial character produces no output. After release, the RX FSM waits in IDLE for the next falling edge.
- A break condition (`rx` held low) yields one `frame_err`, then the FSM stays in WAIT_HIGH until the line returns high.

## Test plan
- Reset: hold `rst` 3 cycles with `rx` = 0 → all outputs 0 and no `frame_err`; after release, raise `rx` → FSM idles, outputs unchanged.
- With `CLKS_PER_BIT` = 8, send `F`,`E`,`_`:
  - After `F`: `rcv` pulse, `data` = 9'h00F.
  - After `E`: `rcv` + `cc_ovf`, `data` = 9'h0FE, `counter` = 1.
  - After `_`: `rcv`, `data` = 9'h15F, no `cc_ovf`.
- Send `5`,`f` → `data` = 9'h05F with `cc_ovf`, bit 8 = 0. Send `a`,`7` → `data` = 9'h0A7, `counter` increments.
- Send `3`,`_`,`G` → `_` gives `rcv`, `data` = 9'h15F, plus `char_err`; `G` gives `char_err` only, no `rcv`. A following `4`,`2` yields 9'h042.
- Stop bit forced low → `frame_err` pulse, no `rcv`. The next valid character decodes normally. Assert `rst` mid-DATA → no output for that character.
- Assert `cnt_clr` on the same cycle as a pair completion → `cc_ovf` pulses and `counter` = 0. Send 256 pairs with `COUNT_W` = 8 → `counter` saturates at 255.

Source files
------------

// File: rtl/mxv_rx_decoder.sv
// UART 8N1 receiver and ASCII hex / '_' symbol decoder feeding the frame control FSM.
// Hex digits pair into bytes; each completed pair pulses cc_ovf and advances a saturating counter.
module mxv_rx_decoder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               cnt_clr,
    output logic               rcv,
    output logic [8:0]         data,
    output logic               cc_ovf,
    output logic [COUNT_W-1:0] counter,
    output logic               frame_err,
    output logic               char_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef logic [8:0] data_dec_t;
    localparam data_dec_t UNDERSCORE = 9'h15F;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Returns {valid, nibble} for an ASCII hex digit, zero otherwise.
    function automatic logic [4:0] hex_decode(input logic [7:0] ch);
        logic [4:0] res;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end else begin
            res = 5'b0_0000;
        end
        return res;
    endfunction

    logic              sync1_r, sync2_r;
    logic              rx_s;
    rx_state_t         state_r, state_nxt_s;
    logic [TIMER_W-1:0] timer_r, timer_nxt_s;
    logic [2:0]        bit_idx_r, bit_idx_nxt_s;
    logic [7:0]        shift_r, shift_nxt_s;
    logic              byte_valid_s;
    logic              stop_low_s;

    logic              pending_r, pending_nxt_s;
    logic [3:0]        hi_r, hi_nxt_s;
    logic [4:0]        hex_s;
    logic              rcv_nxt_s, cc_nxt_s, cerr_nxt_s;
    data_dec_t         data_nxt_s;
    logic [COUNT_W-1:0] counter_nxt_s;

    assign rx_s  = sync2_r;
    assign hex_s = hex_decode(shift_r);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // RX FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            timer_r   <= {TIMER_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // RX FSM next-state: samples mid-bit, starting from the start-bit midpoint.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r + TIMER_W'(1);
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        byte_valid_s  = 1'b0;
        stop_low_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                timer_nxt_s = {TIMER_W{1'b0}};
                if (!rx_s) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (timer_r == HALF_LAST) begin
                    timer_nxt_s   = {TIMER_W{1'b0}};
                    bit_idx_nxt_s = 3'd0;
                    if (rx_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_DATA: begin
                if (timer_r == BIT_LAST) begin
                    timer_nxt_s = {TIMER_W{1'b0}};
                    shift_nxt_s = {rx_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = S_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_STOP: begin
                if (timer_r == BIT_LAST) begin
                    timer_nxt_s = {TIMER_W{1'b0}};
                    if (rx_s) begin
                        byte_valid_s = 1'b1;
                        state_nxt_s  = S_IDLE;
                    end else begin
                        stop_low_s  = 1'b1;
                        state_nxt_s = S_WAIT_HIGH;
                    end
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                timer_nxt_s = {TIMER_W{1'b0}};
                if (rx_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                timer_nxt_s = {TIMER_W{1'b0}};
            end
        endcase
    end

    // Symbol decode; cnt_clr overrides counter and pending but never suppresses pulses.
    always_comb begin
        rcv_nxt_s     = 1'b0;
        cc_nxt_s      = 1'b0;
        cerr_nxt_s    = 1'b0;
        data_nxt_s    = data;
        pending_nxt_s = pending_r;
        hi_nxt_s      = hi_r;
        counter_nxt_s = counter;
        if (byte_valid_s) begin
            if (hex_s[4]) begin
                rcv_nxt_s = 1'b1;
                if (pending_r) begin
                    data_nxt_s    = {1'b0, hi_r, hex_s[3:0]};
                    cc_nxt_s      = 1'b1;
                    pending_nxt_s = 1'b0;
                    if (counter != COUNT_MAX) begin
                        counter_nxt_s = counter + COUNT_W'(1);
                    end else begin
                        counter_nxt_s = counter;
                    end
                end else begin
                    data_nxt_s    = {5'b0_0000, hex_s[3:0]};
                    hi_nxt_s      = hex_s[3:0];
                    pending_nxt_s = 1'b1;
                end
            end else if (shift_r == 8'h5F) begin
                rcv_nxt_s     = 1'b1;
                data_nxt_s    = UNDERSCORE;
                cerr_nxt_s    = pending_r;
                pending_nxt_s = 1'b0;
            end else begin
                cerr_nxt_s = 1'b1;
            end
        end else begin
            rcv_nxt_s = 1'b0;
        end
        if (cnt_clr) begin
            counter_nxt_s = {COUNT_W{1'b0}};
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Registered decoder outputs and pairing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcv       <= 1'b0;
            data      <= 9'h000;
            cc_ovf    <= 1'b0;
            char_err  <= 1'b0;
            frame_err <= 1'b0;
            counter   <= {COUNT_W{1'b0}};
            pending_r <= 1'b0;
            hi_r      <= 4'h0;
        end else begin
            rcv       <= rcv_nxt_s;
            data      <= data_nxt_s;
            cc_ovf    <= cc_nxt_s;
            char_err  <= cerr_nxt_s;
            frame_err <= stop_low_s;
            counter   <= counter_nxt_s;
            pending_r <= pending_nxt_s;
            hi_r      <= hi_nxt_s;
        end
    end

endmodule

// File: tb/tb_mxv_rx_decoder.sv
// Directed bench for mxv_rx_decoder at 8 clocks per bit; output pulses are tallied on the falling edge.
module tb_mxv_rx_decoder;

    localparam int CPB = 8;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          rcv;
    logic [8:0]    data;
    logic          cc_ovf;
    logic [CW-1:0] counter;
    logic          frame_err;
    logic          char_err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_rcv = 0, n_cc = 0, n_cerr = 0, n_ferr = 0;
    int b_rcv = 0, b_cc = 0, b_cerr = 0, b_ferr = 0;

    mxv_rx_decoder #(.CLKS_PER_BIT(CPB), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .cnt_clr   (cnt_clr),
        .rcv       (rcv),
        .data      (data),
        .cc_ovf    (cc_ovf),
        .counter   (counter),
        .frame_err (frame_err),
        .char_err  (char_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rcv)       n_rcv++;
        if (cc_ovf)    n_cc++;
        if (char_err)  n_cerr++;
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_rcv = n_rcv; b_cc = n_cc; b_cerr = n_cerr; b_ferr = n_ferr;
    endtask

    task automatic expect_step(input string tag, input int drcv, input int dcc,
                               input int dcerr, input int dferr, input logic [8:0] dexp);
        check({tag, "_rcv"},  n_rcv - b_rcv, drcv);
        check({tag, "_cc"},   n_cc - b_cc, dcc);
        check({tag, "_cerr"}, n_cerr - b_cerr, dcerr);
        check({tag, "_ferr"}, n_ferr - b_ferr, dferr);
        check({tag, "_data"}, {23'd0, data}, {23'd0, dexp});
    endtask

    // Serial frame: start, 8 data LSB-first, stop; optional cnt_clr on the stop-sample cycle.
    task automatic send(input logic [7:0] ch, input logic stop, input logic clr_on_done);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = ch[i];
            tick(CPB);
        end
        rx = stop;
        if (clr_on_done) begin
            tick(CPB - 2);
            cnt_clr = 1'b1;
            tick(1);
            cnt_clr = 1'b0;
            tick(1);
        end else begin
            tick(CPB);
        end
        rx = 1'b1;
        tick(6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b0;
        tick(3);
        check("rst_rcv", rcv, 1'b0);
        check("rst_data", data, 9'h000);
        check("rst_cc", cc_ovf, 1'b0);
        check("rst_counter", counter, 8'd0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_cerr", char_err, 1'b0);
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        check("idle_ferr_cnt", n_ferr, 0);
        check("idle_rcv_cnt", n_rcv, 0);
        check("idle_data", data, 9'h000);

        snap(); send(8'h46, 1'b1, 1'b0); expect_step("F", 1, 0, 0, 0, 9'h00F);
        snap(); send(8'h45, 1'b1, 1'b0); expect_step("E", 1, 1, 0, 0, 9'h0FE);
        check("E_counter", counter, 8'd1);
        snap(); send(8'h5F, 1'b1, 1'b0); expect_step("us", 1, 0, 0, 0, 9'h15F);

        send(8'h35, 1'b1, 1'b0);
        snap(); send(8'h66, 1'b1, 1'b0); expect_step("5f", 1, 1, 0, 0, 9'h05F);
        check("5f_counter", counter, 8'd2);
        send(8'h61, 1'b1, 1'b0);
        snap(); send(8'h37, 1'b1, 1'b0); expect_step("a7", 1, 1, 0, 0, 9'h0A7);
        check("a7_counter", counter, 8'd3);

        snap(); send(8'h33, 1'b1, 1'b0); expect_step("3", 1, 0, 0, 0, 9'h003);
        snap(); send(8'h5F, 1'b1, 1'b0); expect_step("us_pend", 1, 0, 1, 0, 9'h15F);
        snap(); send(8'h47, 1'b1, 1'b0); expect_step("G", 0, 0, 1, 0, 9'h15F);
        send(8'h34, 1'b1, 1'b0);
        snap(); send(8'h32, 1'b1, 1'b0); expect_step("42", 1, 1, 0, 0, 9'h042);
        check("42_counter", counter, 8'd4);

        snap(); send(8'h41, 1'b0, 1'b0); expect_step("stop_low", 0, 0, 0, 1, 9'h042);
        snap(); send(8'h39, 1'b1, 1'b0); expect_step("after_ferr", 1, 0, 0, 0, 9'h009);

        // Abort mid-DATA with a reset; the partial 'A' must produce nothing.
        snap();
        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(CPB);
        rx = 1'b0; tick(CPB);
        rx = 1'b0; tick(CPB);
        rst = 1'b1; rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(100);
        expect_step("rst_mid", 0, 0, 0, 0, 9'h000);
        check("rst_mid_counter", counter, 8'd0);

        snap();
        rx = 1'b0; tick(200);
        rx = 1'b1; tick(10);
        expect_step("break", 0, 0, 0, 1, 9'h000);

        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b1, 1'b0);
        check("12_counter", counter, 8'd1);
        send(8'h33, 1'b1, 1'b0);
        snap(); send(8'h34, 1'b1, 1'b1); expect_step("clr_pair", 1, 1, 0, 0, 9'h034);
        check("clr_pair_counter", counter, 8'd0);

        snap();
        for (int p = 0; p < 256; p++) begin
            send(8'h30, 1'b1, 1'b0);
            send(8'h30, 1'b1, 1'b0);
        end
        check("sat_cc_cnt", n_cc - b_cc, 256);
        check("sat_counter", counter, 8'd255);
        check("sat_data", data, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
